// File: rtl/cim_gemm_bitserial.sv
// Bit-serial compute-in-memory GeMM macro: ROWS x COLS signed weights, unsigned input
// vector consumed one bit-plane per cycle, results streamed out per column over valid/ready.
module cim_gemm_bitserial #(
   parameter int ROWS = 16,
   parameter int COLS = 4,
   parameter int WW   = 8,
   parameter int IW   = 8,
   parameter int AW   = 32,
   localparam int ADW = $clog2(ROWS*COLS),
   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 CLK,
   input  logic                 RES,
   input  logic                 cs,
   input  logic                 we,
   input  logic [ADW-1:0]       waddr,
   input  logic [WW-1:0]        wdata,
   input  logic                 start,
   input  logic                 acc_en,
   input  logic [ROWS*IW-1:0]   x_vec,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_col,
   output logic [AW-1:0]        out_data,
   output logic                 done
);

   localparam int SW = WW + $clog2(ROWS);
   localparam int BW = (IW > 1) ? $clog2(IW) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN} state_t;

   state_t           r_state, w_state_nx;
   logic [WW-1:0]    r_w   [ROWS*COLS];
   logic [IW-1:0]    r_x   [ROWS];
   logic [AW-1:0]    r_acc [COLS];
   logic [BW-1:0]    r_b;
   logic [CW-1:0]    r_k;
   logic             r_done;
   logic [SW-1:0]    w_s   [COLS];
   logic             w_start, w_we, w_hs, w_last_b, w_last_k;

   assign w_start  = cs & start & (r_state == S_IDLE);
   assign w_we     = cs & we & (r_state == S_IDLE);
   assign w_hs     = (r_state == S_DRAIN) & out_ready;
   assign w_last_b = (r_b == BW'(IW-1));
   assign w_last_k = (r_k == CW'(COLS-1));

   // Per-column sum of the weights selected by the current input bit-plane
   always_comb begin
      for (int unsigned c = 0; c < COLS; c++) begin
         w_s[c] = '0;
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (r_x[r][r_b])
               w_s[c] = w_s[c] + {{(SW-WW){r_w[r*COLS+c][WW-1]}}, r_w[r*COLS+c]};
         end
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:    if (w_start) w_state_nx = S_COMPUTE;
         S_COMPUTE: if (w_last_b) w_state_nx = S_DRAIN;
         S_DRAIN:   if (w_hs && w_last_k) w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         for (int unsigned i = 0; i < ROWS*COLS; i++) r_w[i] <= '0;
         for (int unsigned r = 0; r < ROWS; r++) r_x[r] <= '0;
         for (int unsigned c = 0; c < COLS; c++) r_acc[c] <= '0;
         r_b    <= '0;
         r_k    <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_hs & w_last_k;
         if (w_we) r_w[waddr] <= wdata;
         if (w_start) begin
            for (int unsigned r = 0; r < ROWS; r++) r_x[r] <= x_vec[r*IW +: IW];
            r_b <= '0;
            if (!acc_en)
               for (int unsigned c = 0; c < COLS; c++) r_acc[c] <= '0;
         end
         if (r_state == S_COMPUTE) begin
            r_b <= r_b + 1'b1;
            for (int unsigned c = 0; c < COLS; c++)
               r_acc[c] <= r_acc[c] + ({{(AW-SW){w_s[c][SW-1]}}, w_s[c]} << r_b);
         end
         if (w_hs) r_k <= w_last_k ? '0 : r_k + 1'b1;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_DRAIN);
   assign out_col   = r_k;
   assign out_data  = out_valid ? r_acc[r_k] : '0;
   assign done      = r_done;

endmodule

// File: tb/tb_cim_gemm_bitserial.sv
// Directed self-checking bench for cim_gemm_bitserial (AW=20 so the wrap case is reachable).
module tb_cim_gemm_bitserial;

   localparam int ROWS = 16;
   localparam int COLS = 4;
   localparam int WW   = 8;
   localparam int IW   = 8;
   localparam int AW   = 20;

   logic                CLK = 1'b0;
   logic                RES = 1'b1;
   logic                cs = 1'b0, we = 1'b0, start = 1'b0, acc_en = 1'b0, out_ready = 1'b0;
   logic [5:0]          waddr = '0;
   logic [WW-1:0]       wdata = '0;
   logic [ROWS*IW-1:0]  x_vec = '0;
   logic                busy, out_valid, done;
   logic [1:0]          out_col;
   logic [AW-1:0]       out_data;

   int checks   = 0;
   int failures = 0;
   int n;

   cim_gemm_bitserial #(.ROWS(ROWS), .COLS(COLS), .WW(WW), .IW(IW), .AW(AW)) dut (
      .CLK(CLK), .RES(RES), .cs(cs), .we(we), .waddr(waddr), .wdata(wdata),
      .start(start), .acc_en(acc_en), .x_vec(x_vec), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
      .out_data(out_data), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_x(input int unsigned v);
      for (int r = 0; r < ROWS; r++) x_vec[r*IW +: IW] = v[7:0];
   endtask

   task automatic wr(input int unsigned a, input int d);
      cs = 1'b1; we = 1'b1; waddr = a[5:0]; wdata = d[7:0];
      step();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic launch(input logic acc);
      cs = 1'b1; start = 1'b1; acc_en = acc;
      step();
      cs = 1'b0; start = 1'b0; acc_en = 1'b0;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         step();
         cnt++;
      end
   endtask

   task automatic drain(input string tag, input int e0, input int e1, input int e2, input int e3);
      int e [4];
      int w;
      e = '{e0, e1, e2, e3};
      wait_valid(w);
      out_ready = 1'b1;
      for (int k = 0; k < COLS; k++) begin
         chk($sformatf("%s_valid%0d", tag, k), out_valid, 1);
         chk($sformatf("%s_col%0d", tag, k), out_col, k);
         chk($sformatf("%s_data%0d", tag, k), $signed(out_data), e[k]);
         step();
      end
      out_ready = 1'b0;
      chk($sformatf("%s_done", tag), done, 1);
      chk($sformatf("%s_idle", tag), busy, 0);
      step();
      chk($sformatf("%s_done_clr", tag), done, 0);
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_col", out_col, 0);
      chk("rst_data", $signed(out_data), 0);
      RES = 1'b0;
      step();

      for (int r = 0; r < ROWS; r++) begin
         wr(r*COLS + 0, r + 1);
         wr(r*COLS + 1, -1);
         wr(r*COLS + 2, 0);
         wr(r*COLS + 3, 127);
      end
      set_x(3);

      // Basic launch with latency
      launch(1'b0);
      chk("basic_busy", busy, 1);
      chk("basic_novalid", out_valid, 0);
      wait_valid(n);
      chk("basic_latency", n, 8);
      drain("basic", 408, -48, 0, 6096);

      // Partial-sum chaining
      launch(1'b1);
      drain("psum", 816, -96, 0, 12192);

      // Backpressure
      launch(1'b0);
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         chk($sformatf("bp_hold_col%0d", i), out_col, 0);
         chk($sformatf("bp_hold_data%0d", i), $signed(out_data), 408);
         step();
      end
      drain("bp", 408, -48, 0, 6096);

      // Gating: start without cs, then we/start while busy
      start = 1'b1;
      step();
      start = 1'b0;
      chk("gate_nocs", busy, 0);
      launch(1'b0);
      cs = 1'b1; we = 1'b1; waddr = 6'd0; wdata = 8'd99; start = 1'b1;
      step();
      step();
      cs = 1'b0; we = 1'b0; start = 1'b0;
      drain("gate", 408, -48, 0, 6096);
      chk("gate_nolaunch", busy, 0);

      // Write and start in the same cycle: W[0][0] 1 -> 11 adds 10*3 to col 0
      cs = 1'b1; we = 1'b1; waddr = 6'd0; wdata = 8'd11; start = 1'b1; acc_en = 1'b0;
      step();
      cs = 1'b0; we = 1'b0; start = 1'b0;
      drain("wrst", 438, -48, 0, 6096);

      // Extremes and accumulator wrap
      for (int i = 0; i < ROWS*COLS; i++) wr(i, -128);
      set_x(255);
      launch(1'b0);
      drain("ext", -522240, -522240, -522240, -522240);
      launch(1'b1);
      drain("wrap", 4096, 4096, 4096, 4096);

      // Reset during the third COMPUTE cycle
      launch(1'b0);
      step();
      step();
      RES = 1'b1;
      #1;
      chk("rmid_busy", busy, 0);
      chk("rmid_valid", out_valid, 0);
      chk("rmid_done", done, 0);
      step();
      RES = 1'b0;
      step();
      chk("rmid_nodone", done, 0);
      chk("rmid_idle", busy, 0);
      launch(1'b0);
      drain("clr", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
